// File: rtl/mc_core_pkg.sv
// Shared definitions for mc_core: FSM state encoding, opcode/funct constants,
// ALU control codes and the instruction legality/ALU-select decoder.
package mc_core_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } dec_t;

  // Anything not matched here is illegal and sends the core to HALT.
  function automatic dec_t decode_op(input logic [31:0] ir);
    dec_t d;
    d.legal = 1'b0;
    d.op    = ALU_ADD;
    case (ir[6:0])
      OP_RTYPE: begin
        case ({ir[31:25], ir[14:12]})
          {F7_BASE, F3_ADD}: begin d.legal = 1'b1; d.op = ALU_ADD; end
          {F7_SUB,  F3_ADD}: begin d.legal = 1'b1; d.op = ALU_SUB; end
          {F7_BASE, F3_AND}: begin d.legal = 1'b1; d.op = ALU_AND; end
          {F7_BASE, F3_OR }: begin d.legal = 1'b1; d.op = ALU_OR;  end
          {F7_BASE, F3_SLT}: begin d.legal = 1'b1; d.op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ITYPE: begin
        case (ir[14:12])
          F3_ADD: begin d.legal = 1'b1; d.op = ALU_ADD; end
          F3_AND: begin d.legal = 1'b1; d.op = ALU_AND; end
          F3_OR:  begin d.legal = 1'b1; d.op = ALU_OR;  end
          F3_SLT: begin d.legal = 1'b1; d.op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LOAD:   d.legal = (ir[14:12] == F3_LW);
      OP_STORE:  d.legal = (ir[14:12] == F3_SW);
      OP_BRANCH: begin d.legal = (ir[14:12] == F3_BEQ); d.op = ALU_SUB; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file for mc_core: two asynchronous reads, one synchronous write.
// x0 and indices at or above NREG read as zero and discard writes.
module mc_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [4:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  localparam int          IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned NREG_U = NREG;

  logic [DATA_W-1:0] regs_q [NREG];

  function automatic logic mapped(input logic [4:0] a);
    return (a != 5'd0) && (32'(a) < NREG_U);
  endfunction

  assign rdata1_o = mapped(raddr1_i) ? regs_q[raddr1_i[IW-1:0]] : '0;
  assign rdata2_o = mapped(raddr2_i) ? regs_q[raddr2_i[IW-1:0]] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG_U; i++) regs_q[i] <= '0;
    end else if (we_i && mapped(waddr_i)) begin
      regs_q[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle RV32-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define MC_CORE_SINGLE_STEP_EN to add the step port and single-step fetch gating.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 32
) (
  input  logic              clock_reg,
  input  logic              reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [31:0]       instr_rdata,
  input  logic              instr_ready,
  output logic              data_req,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              zero
`ifdef MC_CORE_SINGLE_STEP_EN
  ,
  input  logic              step
`endif
);

  state_e            state_q, state_d;
  logic              running_q;
  logic [ADDR_W-1:0] pc_q, old_pc_q, boff_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  logic              zero_q;

  dec_t              dec;
  logic              is_r, is_load, is_store, is_branch;
  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic [DATA_W-1:0] rs1_val, rs2_val, opb, alu_res;
  logic              fetch_go, mem_done, step_ok;

  always_comb begin
    dec       = decode_op(ir_q);
    is_r      = (ir_q[6:0] == OP_RTYPE);
    is_load   = (ir_q[6:0] == OP_LOAD);
    is_store  = (ir_q[6:0] == OP_STORE);
    is_branch = (ir_q[6:0] == OP_BRANCH);
    imm_i     = ir_q[31:20];
    imm_s     = {ir_q[31:25], ir_q[11:7]};
    imm_b     = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  end

  always_comb begin
    opb = (is_r || is_branch) ? b_q : imm_q;
    case (dec.op)
      ALU_ADD: alu_res = a_q + opb;
      ALU_SUB: alu_res = a_q - opb;
      ALU_AND: alu_res = a_q & opb;
      ALU_OR:  alu_res = a_q | opb;
      ALU_SLT: alu_res = DATA_W'($signed(a_q) < $signed(opb));
      default: alu_res = '0;
    endcase
  end

  mc_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk_i    (clock_reg),
    .rst_i    (reset),
    .raddr1_i (ir_q[19:15]),
    .rdata1_o (rs1_val),
    .raddr2_i (ir_q[24:20]),
    .rdata2_o (rs2_val),
    .we_i     (state_q == S_WB),
    .waddr_i  (ir_q[11:7]),
    .wdata_i  (is_load ? mdr_q : alu_q)
  );

`ifdef MC_CORE_SINGLE_STEP_EN
  logic [2:0] step_sync_q;
  logic       step_pend_q;

  // One-deep pending flag: a rising edge seen mid-instruction arms the next fetch.
  always_ff @(posedge clock_reg or posedge reset) begin
    if (reset) begin
      step_sync_q <= '0;
      step_pend_q <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[1:0], step};
      step_pend_q <= (step_pend_q & ~fetch_go) | (step_sync_q[1] & ~step_sync_q[2]);
    end
  end
  assign step_ok = step_pend_q;
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge clock_reg or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_go) state_d = S_DECODE;
      S_DECODE: state_d = dec.legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_branch)                state_d = S_FETCH;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM:    if (mem_done) state_d = is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // running_q keeps instr_req low for the first cycle after reset release.
  always_comb begin
    instr_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    case (state_q)
      S_FETCH: instr_req = running_q & step_ok;
      S_MEM: begin
        data_req = 1'b1;
        data_we  = is_store;
      end
      default: ;
    endcase
  end

  assign fetch_go   = instr_req & instr_ready;
  assign mem_done   = data_req & data_ready;
  assign instr_addr = pc_q;
  assign data_addr  = ADDR_W'(alu_q);
  assign data_wdata = b_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign zero       = zero_q;

  always_ff @(posedge clock_reg or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      pc_q      <= '0;
      old_pc_q  <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      boff_q    <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      running_q <= 1'b1;
      case (state_q)
        S_FETCH: if (fetch_go) begin
          ir_q     <= instr_rdata;
          old_pc_q <= pc_q;
          pc_q     <= pc_q + ADDR_W'(4);
        end
        S_DECODE: begin
          a_q    <= rs1_val;
          b_q    <= rs2_val;
          imm_q  <= DATA_W'(is_store ? imm_s : imm_i);
          boff_q <= ADDR_W'(imm_b);
          if (!dec.legal) pc_q <= old_pc_q;
        end
        S_EXEC: begin
          alu_q  <= alu_res;
          zero_q <= (alu_res == '0);
          if (is_branch && alu_res == '0) pc_q <= old_pc_q + boff_q;
        end
        S_MEM: if (mem_done && is_load) mdr_q <= data_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Directed self-checking bench for mc_core with a writable instruction ROM
// and a data memory whose ready response is delayed by dwait cycles.
module tb_mc_core;

  logic        clock_reg = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_ready = 1'b1;
  logic        data_req, data_we;
  logic [7:0]  data_addr, data_wdata, data_rdata;
  logic        data_ready;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        halted, zero;

  logic [31:0] rom [64];
  logic [7:0]  dmem [256];
  int          dwait = 0;
  int          wcnt = 0;
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  mc_core #(.DATA_W(8), .ADDR_W(8), .NREG(32)) dut (
    .clock_reg   (clock_reg),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .instr_ready (instr_ready),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_ready  (data_ready),
    .pc          (pc),
    .state       (state),
    .halted      (halted),
    .zero        (zero)
  );

  always #5 clock_reg = ~clock_reg;

  assign instr_rdata = rom[instr_addr[7:2]];
  assign data_rdata  = dmem[data_addr];
  assign data_ready  = data_req && (wcnt >= dwait);

  always @(posedge clock_reg) begin
    if (data_req) wcnt <= wcnt + 1;
    else          wcnt <= 0;
    if (data_req && data_we && data_ready) dmem[data_addr] <= data_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xreg(input int n);
    return dut.u_rf.regs_q[n];
  endfunction

  // Runs one instruction from its fetch until the FSM is back in FETCH (or HALT).
  task automatic run_instr(input string tag, input int exp_cyc, input int exp_stall);
    int   cyc = 0;
    int   stall = 0;
    logic seen = 1'b0;
    logic moved = 1'b0;
    logic [7:0] a0 = '0;
    while (!instr_req && cyc < 20) begin
      @(negedge clock_reg);
      cyc++;
    end
    cyc = 0;
    do begin
      if (data_req) begin
        if (!seen) begin a0 = data_addr; seen = 1'b1; end
        else if (data_addr !== a0) moved = 1'b1;
        if (!data_ready) stall++;
      end
      @(negedge clock_reg);
      cyc++;
    end while (state !== 3'd0 && state !== 3'd5 && cyc < 40);
    if (exp_cyc >= 0) check({tag, " cycles"}, cyc, exp_cyc);
    if (exp_stall >= 0) begin
      check({tag, " req wait"}, stall, exp_stall);
      check({tag, " addr stable"}, {31'b0, moved}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000007F;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    rom[0]  = 32'h00500093; // addi x1,x0,5
    rom[1]  = 32'h00102023; // sw   x1,0(x0)
    rom[2]  = 32'hFE000EE3; // beq  x0,x0,-4
    rom[3]  = 32'h06400113; // addi x2,x0,100
    rom[4]  = 32'h002081B3; // add  x3,x1,x2
    rom[5]  = 32'h40108233; // sub  x4,x1,x1
    rom[6]  = 32'h0020A333; // slt  x6,x1,x2
    rom[7]  = 32'hFFF0A393; // slti x7,x1,-1
    rom[8]  = 32'h00F0F413; // andi x8,x1,15
    rom[9]  = 32'h0020E4B3; // or   x9,x1,x2
    rom[10] = 32'h00700013; // addi x0,x0,7
    rom[11] = 32'h00208463; // beq  x1,x2,+8
    rom[12] = 32'h0C000663; // beq  x0,x0,+204
    rom[63] = 32'h00100593; // addi x11,x0,1

    #2;
    check("rst pc", pc, 0);
    check("rst state", state, 0);
    check("rst instr_req", instr_req, 0);
    check("rst data_req", data_req, 0);
    check("rst data_we", data_we, 0);
    check("rst halted", halted, 0);
    check("rst zero", zero, 0);
    repeat (2) @(negedge clock_reg);
    reset = 1'b0;
    #1;
    check("release instr_req", instr_req, 0);
    @(negedge clock_reg);
    check("first fetch req", instr_req, 1);
    check("first fetch addr", instr_addr, 0);

    run_instr("addi x1", 4, -1);
    check("x1=5", xreg(1), 5);
    check("pc after addi", pc, 4);

    dwait = 3;
    run_instr("sw", 7, 3);
    check("mem[0] stored", dmem[0], 5);
    rom[1] = 32'h00002283; // lw x5,0(x0)
    dwait = 0;
    run_instr("beq taken", 3, -1);
    check("beq target", instr_addr, 4);
    rom[2] = 32'h0C800093; // addi x1,x0,200
    dwait = 3;
    run_instr("lw", 8, 3);
    check("x5=5", xreg(5), 5);
    dwait = 0;

    run_instr("addi x1 200", 4, -1);
    run_instr("addi x2 100", 4, -1);
    run_instr("add", 4, -1);
    check("x3 wrap", xreg(3), 44);
    check("zero after add", zero, 0);
    run_instr("sub", 4, -1);
    check("x4", xreg(4), 0);
    check("zero after sub", zero, 1);
    run_instr("slt", 4, -1);
    check("slt signed", xreg(6), 1);
    run_instr("slti", 4, -1);
    check("slti signed", xreg(7), 1);
    run_instr("andi", 4, -1);
    check("andi", xreg(8), 8'h08);
    run_instr("or", 4, -1);
    check("or", xreg(9), 8'hEC);
    run_instr("addi x0", 4, -1);
    check("x0 stays 0", xreg(0), 0);
    run_instr("beq not taken", 3, -1);
    check("pc no branch", pc, 8'h30);
    rom[0] = 32'h00000013; // nop
    rom[1] = 32'h0000007F; // illegal opcode
    run_instr("beq far", 3, -1);
    check("pc far", pc, 8'hFC);
    run_instr("addi at 252", 4, -1);
    check("pc wrap", pc, 0);
    check("x11", xreg(11), 1);
    run_instr("nop", 4, -1);
    run_instr("illegal", -1, -1);
    check("halted", halted, 1);
    check("halt pc", pc, 4);
    repeat (3) @(negedge clock_reg);
    check("halt sticky", state, 5);
    check("halt no fetch", instr_req, 0);
    check("halt pc kept", pc, 4);

    rom[0] = 32'h00002603; // lw x12,0(x0)
    dwait = 10;
    reset = 1'b1;
    @(negedge clock_reg);
    check("rst leaves halt", halted, 0);
    reset = 1'b0;
    for (int i = 0; i < 20 && state !== 3'd3; i++) @(negedge clock_reg);
    check("reached MEM", state, 3);
    @(negedge clock_reg);
    check("mem pending", data_req, 1);
    #2 reset = 1'b1;
    #1;
    check("mid-MEM data_req", data_req, 0);
    check("mid-MEM pc", pc, 0);
    check("mid-MEM state", state, 0);
    check("mid-MEM x12", xreg(12), 0);
    @(negedge clock_reg);
    reset = 1'b0;
    dwait = 0;
    run_instr("lw zero-wait", 5, 0);
    check("x12=5", xreg(12), 5);
    check("pc after lw", pc, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
